// File: rtl/operand_tf_pkg.sv
// Shared parameters and write-side state encoding for
// the ping-pong operand loader.
package operand_tf_pkg;

    localparam int ELEM_W_DEF     = 8;
    localparam int NUM_ELEM_DEF   = 32;
    localparam int BEAT_ELEMS_DEF = 4;

    typedef enum logic [1:0] {
        W_EMPTY = 2'd0,
        W_FILL  = 2'd1,
        W_STALL = 2'd2
    } w_state_t;

endpackage

// File: rtl/operand_tf_bank.sv
// One vector bank: writes a beat into its lane group and
// optionally zeroes every other lane in the same cycle.
module operand_tf_bank #(
    parameter int ELEM_W     = 8,
    parameter int NUM_ELEM   = 32,
    parameter int BEAT_ELEMS = 4,
    parameter int SEL_W      = 3
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic                           clr_others,
    input  logic [SEL_W-1:0]               sel,
    input  logic [BEAT_ELEMS*ELEM_W-1:0]   wdata,
    output logic [NUM_ELEM*ELEM_W-1:0]     q
);

    localparam int BEAT_W = BEAT_ELEMS * ELEM_W;

    logic [NUM_ELEM*ELEM_W-1:0] q_nxt;

    always_comb begin
        q_nxt = clr_others ? '0 : q;
        q_nxt[sel*BEAT_W +: BEAT_W] = wdata;
    end

    // Contents are don't-care after reset; full flags gate use.
    always_ff @(posedge clk) begin
        if (we)
            q <= q_nxt;
    end

endmodule

// File: rtl/operand_tf_loader.sv
// Assembles beats into full operand vectors in two ping-pong
// banks and hands them to the transformer with valid/ready.
module operand_tf_loader
    import operand_tf_pkg::*;
#(
    parameter int ELEM_W     = ELEM_W_DEF,
    parameter int NUM_ELEM   = NUM_ELEM_DEF,
    parameter int BEAT_ELEMS = BEAT_ELEMS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [BEAT_ELEMS*ELEM_W-1:0]   s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]     m_data,
    output logic                           err_overrun
);

    localparam int BEATS = NUM_ELEM / BEAT_ELEMS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    w_state_t         w_state;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_nxt;
    logic             accept;
    logic             handoff;
    logic             at_end;
    logic             commit;

    logic [NUM_ELEM*ELEM_W-1:0] bank_q [2];

    // STALL is registered from next-state full[wr_bank].
    assign s_ready = rst_n && !flush && (w_state != W_STALL);
    assign m_valid = rst_n && !flush && full[rd_bank];
    assign m_data  = bank_q[rd_bank];

    assign accept  = s_valid && s_ready;
    assign handoff = m_valid && m_ready;
    assign at_end  = (beat_cnt == LAST_BEAT);
    assign commit  = accept && (s_last || at_end);

    always_comb begin
        full_nxt = full;
        if (handoff)
            full_nxt[rd_bank] = 1'b0;
        if (commit)
            full_nxt[wr_bank] = 1'b1;
        wr_nxt  = wr_bank ^ commit;
        cnt_nxt = beat_cnt;
        if (commit)
            cnt_nxt = '0;
        else if (accept)
            cnt_nxt = beat_cnt + 1'b1;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        operand_tf_bank #(
            .ELEM_W     (ELEM_W),
            .NUM_ELEM   (NUM_ELEM),
            .BEAT_ELEMS (BEAT_ELEMS),
            .SEL_W      (CNT_W)
        ) u_bank (
            .clk        (clk),
            .we         (accept && (wr_bank == 1'(b))),
            .clr_others (beat_cnt == '0),
            .sel        (beat_cnt),
            .wdata      (s_data),
            .q          (bank_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            w_state     <= W_EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            full        <= full_nxt;
            wr_bank     <= wr_nxt;
            rd_bank     <= rd_bank ^ handoff;
            beat_cnt    <= cnt_nxt;
            err_overrun <= accept && at_end && !s_last;
            case (w_state)
                W_EMPTY, W_FILL: begin
                    if (full_nxt[wr_nxt])
                        w_state <= W_STALL;
                    else if (cnt_nxt == '0)
                        w_state <= W_EMPTY;
                    else
                        w_state <= W_FILL;
                end
                W_STALL: begin
                    if (!full_nxt[wr_bank])
                        w_state <= W_EMPTY;
                end
                default: w_state <= W_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_tf_loader.sv
// Bench for operand_tf_loader: beat-level model feeds a
// scoreboard of expected vectors checked at each handoff.
module tb_operand_tf_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic         err_overrun;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int ovr_seen = 0;
    int stalls = 0;

    logic [255:0] exp_q [$];
    logic [255:0] mdl_vec = '0;
    int           mdl_cnt = 0;

    typedef struct {
        int nbeats;
        bit with_last;
        int exp_vecs;
        int exp_ovr;
    } row_t;

    row_t rows [7];

    operand_tf_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err_overrun === 1'b1)
            ovr_seen++;
        if (rst_n && m_valid === 1'b1 && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handoff: got %0h expected none",
                         m_data);
            end else begin
                chk("vector", m_data, exp_q.pop_front());
            end
            hs_count++;
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit last);
        int w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (s_ready !== 1'b1 && w < 300) begin
            stalls++;
            w++;
            @(negedge clk);
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got s_ready=%b expected 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (mdl_cnt == 0)
            mdl_vec = '0;
        mdl_vec[mdl_cnt*32 +: 32] = d;
        if (last || mdl_cnt == 7) begin
            exp_q.push_back(mdl_vec);
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic send_vec(input int nbeats, input bit with_last,
                            input logic [7:0] base);
        logic [31:0] d;
        for (int b = 0; b < nbeats; b++) begin
            for (int e = 0; e < 4; e++)
                d[e*8 +: 8] = base + 8'(b*4 + e);
            send_beat(d, with_last && (b == nbeats - 1));
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", 256'(exp_q.size()), 256'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic abort_test(input bit use_flush);
        int h0;
        m_ready = 1'b0;
        send_vec(8, 1'b1, 8'h40);
        send_vec(5, 1'b0, 8'h60);
        idle();
        chk("pre_abort_mvalid", 256'(m_valid), 256'd1);
        if (use_flush) begin
            flush   = 1'b1;
            s_valid = 1'b1;
            s_data  = 32'hdeadbeef;
        end else begin
            rst_n = 1'b0;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        rst_n = 1'b1;
        idle();
        #1;
        chk("abort_mvalid", 256'(m_valid), 256'd0);
        chk("abort_sready", 256'(s_ready), 256'd1);
        exp_q.delete();
        mdl_cnt = 0;
        m_ready = 1'b1;
        h0 = hs_count;
        send_vec(8, 1'b1, 8'h80);
        idle();
        drain();
        chk("abort_fresh_vec", 256'(hs_count - h0), 256'd1);
    endtask

    initial begin
        int h0;
        int o0;
        logic [255:0] ramp;

        rows[0] = '{8,  1'b1, 1, 0};
        rows[1] = '{3,  1'b1, 1, 0};
        rows[2] = '{8,  1'b0, 1, 1};
        rows[3] = '{9,  1'b1, 2, 1};
        rows[4] = '{1,  1'b1, 1, 0};
        rows[5] = '{16, 1'b0, 2, 2};
        rows[6] = '{12, 1'b1, 2, 1};

        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", 256'(s_ready), 256'd0);
        chk("rst_mvalid", 256'(m_valid), 256'd0);
        chk("rst_overrun", 256'(err_overrun), 256'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_sready", 256'(s_ready), 256'd1);

        // ramp vector, element k == k, one cycle to m_valid
        for (int k = 0; k < 32; k++)
            ramp[k*8 +: 8] = 8'(k);
        send_vec(8, 1'b1, 8'h00);
        idle();
        chk("ramp_latency", 256'(m_valid), 256'd1);
        chk("ramp_data", m_data, ramp);
        chk("ramp_overrun", 256'(err_overrun), 256'd0);
        drain();

        // short vector is zero-padded
        m_ready = 1'b0;
        send_vec(3, 1'b1, 8'h00);
        idle();
        chk("short_mvalid", 256'(m_valid), 256'd1);
        chk("short_pad", 256'(m_data[255:96]), 256'd0);
        chk("short_data", 256'(m_data[95:0]),
            256'(96'h0b0a0908_07060504_03020100));
        m_ready = 1'b1;
        drain();

        for (int i = 0; i < 7; i++) begin
            h0 = hs_count;
            o0 = ovr_seen;
            send_vec(rows[i].nbeats, rows[i].with_last, 8'(i * 37 + 5));
            idle();
            drain();
            chk($sformatf("row%0d_vecs", i), 256'(hs_count - h0),
                256'(rows[i].exp_vecs));
            chk($sformatf("row%0d_ovr", i), 256'(ovr_seen - o0),
                256'(rows[i].exp_ovr));
        end

        // both banks full, third vector waits
        m_ready = 1'b0;
        h0 = hs_count;
        send_vec(8, 1'b1, 8'h10);
        send_vec(8, 1'b1, 8'h50);
        idle();
        chk("two_full_sready", 256'(s_ready), 256'd0);
        chk("two_full_no_hs", 256'(hs_count - h0), 256'd0);
        fork
            send_vec(8, 1'b1, 8'h90);
            begin
                repeat (4) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("two_full_hs", 256'(hs_count - h0), 256'd3);

        // continuous streaming
        stalls = 0;
        h0 = hs_count;
        for (int v = 0; v < 4; v++)
            send_vec(8, 1'b1, 8'(v * 32 + 3));
        idle();
        drain();
        chk("stream_stalls", 256'(stalls), 256'd0);
        chk("stream_hs", 256'(hs_count - h0), 256'd4);

        abort_test(1'b0);
        abort_test(1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_tf_loader.md
OPERAND_TF_LOADER -- requirements
Module: operand_tf_loader

Interface
REQ-001 Parameter ELEM_W, default 8: width of one operand element in bits.
REQ-002 Parameter NUM_ELEM, default 32: elements per flattened operand vector.
REQ-003 Parameter BEAT_ELEMS, default 4: elements per input beat; BEATS = NUM_ELEM/BEAT_ELEMS = 8.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous clear of the partial vector and both banks.
REQ-007 s_valid  input  1  beat valid.
REQ-008 s_ready  output  1  loader can accept a beat.
REQ-009 s_data  input  BEAT_ELEMS*ELEM_W  beat payload; element 0 in the LSBs.
REQ-010 s_last  input  1  final beat of the vector.
REQ-011 m_valid  output  1  full vector available; drives the transformer valid_in.
REQ-012 m_ready  input  1  downstream accepts; driven by the transformer ready_in.
REQ-013 m_data  output  NUM_ELEM*ELEM_W  assembled vector; element 0 in the LSBs.
REQ-014 err_overrun  output  1  one-cycle pulse when a vector closes at BEATS with s_last=0.

Function
REQ-015 Beat accepted iff s_valid && s_ready; vector handed off iff m_valid && m_ready.
REQ-016 Two vector banks (ping-pong): wr_bank pointer, rd_bank pointer, full[1:0] flags.
REQ-017 s_ready = !full[wr_bank] && !flush; m_valid = full[rd_bank] && !flush; m_data = bank[rd_bank], combinational from the registered bank.
REQ-018 Beat counter beat_cnt (log2 BEATS bits): an accepted beat writes s_data to lanes [beat_cnt*BEAT_ELEMS +: BEAT_ELEMS] of bank[wr_bank].
REQ-019 On an accepted beat with beat_cnt==0: lanes of bank[wr_bank] not written this cycle are cleared to zero, so a short vector is zero-padded.
REQ-020 Commit, on an accepted beat with s_last=1 or beat_cnt==BEATS-1: set full[wr_bank], toggle wr_bank, beat_cnt<=0; otherwise beat_cnt increments.
REQ-021 Accepted beat with beat_cnt==BEATS-1 and s_last=0: commit anyway and pulse err_overrun for 1 cycle; the next beat starts a new vector.
REQ-022 Handoff clears full[rd_bank] and toggles rd_bank.
REQ-023 Commit and handoff in the same cycle are both honoured; full flags are updated independently per bank.
REQ-024 Write-side FSM:
- W_EMPTY (beat_cnt==0) -> W_FILL on an accepted beat without commit.
- W_FILL -> W_EMPTY on commit.
- W_EMPTY/W_FILL -> W_STALL when full[wr_bank] is set.
- W_STALL -> W_EMPTY when that bank is released.
REQ-025 Latency: first beat to m_valid is beat count + 0 cycles; m_valid asserts the cycle after the committing beat.
REQ-026 m_valid stays asserted and m_data stays stable until the handoff.
REQ-027 Zero-bubble streaming: with m_ready=1 constantly, s_ready never deasserts.
REQ-028 flush=1: next cycle full=0, beat_cnt=0, wr_bank=rd_bank=0, FSM=W_EMPTY; beats presented during flush are dropped.

Reset
REQ-029 rst_n=0 at a clock edge yields: s_ready=0 during reset, then 1; m_valid=0; err_overrun=0; full=0; beat_cnt=0; pointers=0; FSM=W_EMPTY; bank contents are don't-care.
REQ-030 Reset mid-vector discards the partial vector and any unconsumed banks; no spurious m_valid follows.

Structure
REQ-031 ELEM_W, NUM_ELEM, BEAT_ELEMS defaults and the write FSM state typedef live in operand_tf_pkg.
REQ-032 One sub-module: operand_tf_bank, one NUM_ELEM-lane register with beat-lane write enable and clear-others; instantiated twice.

Verification
REQ-033 Eight beats with data 0x03020100, 0x07060504 ... and s_last on beat 8, m_ready=1: m_valid the next cycle, m_data element k == k, err_overrun=0.
REQ-034 Three beats with s_last on beat 3: elements 0-11 carry data, elements 12-31 == 0, m_valid asserts.
REQ-035 m_ready=0, send three full vectors: first two fill both banks, s_ready=0 after the 16th beat; raising m_ready drains vectors in order, then the third is accepted.
REQ-036 Eight beats with s_last=0 throughout: err_overrun pulses once at beat 8, the vector is delivered, and the 9th beat lands in lanes 0-3 of a new vector.
REQ-037 Continuous stream of 4 vectors with m_ready=1: s_ready held at 1 for 32 cycles and 4 handoffs occur.
REQ-038 Assert rst_n=0 (or flush=1) after 5 beats with one bank full: m_valid=0 the next cycle, and a fresh 8-beat vector is delivered correctly afterward.
